data_mem_arbiter: RTL
=====================

// Module: data_mem_arbiter
// PURPOSE
//  Shares the single-port data memory between the load unit and the store-commit unit.
//  Accepts one request at a time, drives the memory's rw_flag/addr/data/mask, waits for completion,
//  and returns read data with the load's tag, or a store-done pulse. All memory accesses are serialized.
//  Sits between the LSB/ROB commit logic and the data memory.
// PARAMETERS
//  TAG_W   3   width of the load tag returned with read data
//  Widths `Addr_Width and `Data_Width come from the shared defines file.
// PORTS
//  clk             in   1            system clock
//  rst             in   1            synchronous reset, active-low (asserted when 0)
//  ld_req          in   1            load request; held with payload until ld_grant
//  ld_addr         in   Addr_Width   load byte address
//  ld_tag          in   TAG_W        load tag
//  ld_grant        out  1            1-cycle pulse: load payload accepted this cycle
//  ld_done         out  1            1-cycle pulse: ld_data/ld_tag_out valid
//  ld_data         out  Data_Width   read word
//  ld_tag_out      out  TAG_W        tag of the completed load
//  st_req          in   1            store request; held with payload until st_grant
//  st_addr/st_data in   Addr_Width/Data_Width   store address / data
//  st_mask         in   4            byte-enable mask, bit i = byte i
//  st_grant        out  1            1-cycle pulse: store payload accepted
//  st_done         out  1            1-cycle pulse: store written to memory
//  mem_free        in   1            memory is in its ready state
//  mem_read_valid  in   1            memory read data valid (1-cycle pulse)
//  mem_o_data      in   Data_Width   memory read data
//  mem_rw_flag     out  2            [1]=read, [0]=write; nonzero for exactly one cycle per access
//  mem_addr/mem_i_data/mem_mask  out  Addr_Width/Data_Width/4   held stable from issue until done
//  busy            out  1            high in any state other than IDLE
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=IDLE; every output 0 (incl. ld_data, mem_addr); RR pointer -> store.
//  FSM: IDLE -> ISSUE -> WAIT -> IDLE. All outputs are registered.
//   IDLE:  if mem_free and any req: pulse the winner's grant; latch its payload and op type; go to ISSUE.
//          The grant is combinational from req/state; the payload is latched on the same edge.
//   ISSUE: drive mem_rw_flag (2'b10 for a load, 2'b01 for a store) for this one cycle only; go to WAIT.
//   WAIT:  rw_flag=0. On the first cycle with mem_free==1 (mem_free is guaranteed 0 in the first WAIT cycle):
//          load -> capture mem_o_data (mem_read_valid must be 1) into ld_data, pulse ld_done next cycle;
//          store -> pulse st_done next cycle. Go to IDLE.
//  Latency with grant at cycle T: ISSUE at T+1, mem completes at T+4, ld_done/st_done high at T+5.
//   A new grant is allowed at T+5, in the same cycle as the done pulse.
//  Arbitration, both req in IDLE: fixed priority, store first (macro off).
//  Requests while busy are ignored, not queued; the requester keeps req high.
//  A req dropped before its grant is simply not served.
//  mem_read_valid seen outside WAIT-for-load: ignored; no ld_done.
//  Reset mid-access: abandon the access and return to IDLE; no done pulse. The memory shares this reset.
//  mem_addr/mem_i_data/mem_mask change only on a grant edge.
// CONFIGURATION
//  MEM_ARB_RR_EN defined: round-robin. When both req, serve the type not served by the last grant.
//   The pointer updates on every grant. When only one requests, it wins regardless.
//  MEM_ARB_RR_EN undefined: store always wins a tie. No pointer register exists.
// STRUCTURE
//  Shared package/defines: `Addr_Width, `Data_Width, the rw_flag encodings (RW_READ=2'b10, RW_WRITE=2'b01),
//   and the FSM state localparams (IDLE/ISSUE/WAIT, 2 bits).
//  One sub-module, mem_arb_pick: combinational winner select from ld_req, st_req and the RR pointer.
//  The FSM and payload registers stay in data_mem_arbiter.
// TESTING (bench includes a cycle-accurate data memory model: free, 2-cycle delay, read_valid pulse)
//  1 load addr=0x10 tag=5, mem[4]=0xDEADBEEF -> ld_grant@T, rw_flag=10@T+1, ld_done@T+5 data=0xDEADBEEF tag=5
//  2 store addr=0x8 data=0x11223344 mask=4'b0101 over 0xFFFFFFFF -> st_done@T+5; readback 0xFF22FF44
//  3 ld_req and st_req both held from T -> store granted first; load granted at T+5; ld_done at T+10
//  4 MEM_ARB_RR_EN: both held for 4 accesses -> grants alternate st,ld,st,ld
//  5 rst=0 at T+2 of a load -> at T+3 all outputs 0, busy=0, no ld_done; next load completes normally
//  6 ld_req pulsed while busy then dropped -> never granted, rw_flag stays 0 after the current access

Source files
------------

// File: rtl/data_mem_arbiter_pkg.sv
// data_mem_arbiter_pkg: shared widths, rw_flag encodings and FSM states for data_mem_arbiter.
`ifndef Addr_Width
`define Addr_Width 32
`endif
`ifndef Data_Width
`define Data_Width 32
`endif
package data_mem_arbiter_pkg;
    localparam logic [1:0] RW_READ  = 2'b10;
    localparam logic [1:0] RW_WRITE = 2'b01;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner select between load and store requests.
module mem_arb_pick (
    input  logic ld_req,
    input  logic st_req,
    input  logic prefer_st,
    output logic pick_ld,
    output logic pick_st
);
    assign pick_st = st_req && (!ld_req || prefer_st);
    assign pick_ld = ld_req && !pick_st;
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: serializes load and store-commit accesses onto the single-port data memory.
// MEM_ARB_RR_EN selects round-robin tie-breaking; otherwise a store always wins a tie.
`ifndef Addr_Width
`define Addr_Width 32
`endif
`ifndef Data_Width
`define Data_Width 32
`endif
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int TAG_W = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ld_req,
    input  logic [`Addr_Width-1:0] ld_addr,
    input  logic [TAG_W-1:0]       ld_tag,
    output logic                   ld_grant,
    output logic                   ld_done,
    output logic [`Data_Width-1:0] ld_data,
    output logic [TAG_W-1:0]       ld_tag_out,
    input  logic                   st_req,
    input  logic [`Addr_Width-1:0] st_addr,
    input  logic [`Data_Width-1:0] st_data,
    input  logic [3:0]             st_mask,
    output logic                   st_grant,
    output logic                   st_done,
    input  logic                   mem_free,
    input  logic                   mem_read_valid,
    input  logic [`Data_Width-1:0] mem_o_data,
    output logic [1:0]             mem_rw_flag,
    output logic [`Addr_Width-1:0] mem_addr,
    output logic [`Data_Width-1:0] mem_i_data,
    output logic [3:0]             mem_mask,
    output logic                   busy
);
    state_t           state;
    logic             op_ld;
    logic [TAG_W-1:0] tag_q;
    logic             prefer_st;
    logic             pick_ld;
    logic             pick_st;

    mem_arb_pick u_pick (
        .ld_req   (ld_req),
        .st_req   (st_req),
        .prefer_st(prefer_st),
        .pick_ld  (pick_ld),
        .pick_st  (pick_st)
    );

    assign ld_grant = (state == IDLE) && mem_free && pick_ld;
    assign st_grant = (state == IDLE) && mem_free && pick_st;

`ifdef MEM_ARB_RR_EN
    // After a load the store side is preferred next, and vice versa.
    always_ff @(posedge clk) begin
        if (!rst)
            prefer_st <= 1'b1;
        else if (ld_grant || st_grant)
            prefer_st <= ld_grant;
    end
`else
    assign prefer_st = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            op_ld       <= 1'b0;
            tag_q       <= '0;
            ld_done     <= 1'b0;
            st_done     <= 1'b0;
            ld_data     <= '0;
            ld_tag_out  <= '0;
            mem_rw_flag <= 2'b00;
            mem_addr    <= '0;
            mem_i_data  <= '0;
            mem_mask    <= 4'b0;
        end else begin
            ld_done     <= 1'b0;
            st_done     <= 1'b0;
            mem_rw_flag <= 2'b00;
            case (state)
                IDLE: if (ld_grant || st_grant) begin
                    state       <= ISSUE;
                    busy        <= 1'b1;
                    op_ld       <= ld_grant;
                    tag_q       <= ld_tag;
                    mem_rw_flag <= ld_grant ? RW_READ : RW_WRITE;
                    mem_addr    <= ld_grant ? ld_addr : st_addr;
                    mem_i_data  <= ld_grant ? '0 : st_data;
                    mem_mask    <= ld_grant ? 4'b0 : st_mask;
                end
                ISSUE: state <= WAIT;
                WAIT: if (mem_free && (mem_read_valid || !op_ld)) begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    ld_done <= op_ld;
                    st_done <= !op_ld;
                    if (op_ld) begin
                        ld_data    <= mem_o_data;
                        ld_tag_out <= tag_q;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
